// File: rtl/imem_block_reader.sv
// Instruction memory (64 x 16-byte blocks) serving cache refills with a fixed, cycle-counted read latency.
// Contents start unknown and are loaded through the byte-wide programming port.
module imem_block_reader #(
    parameter int    READ_LATENCY = 5,
    parameter string INIT_FILE    = "imem_init.hex"
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mem_read,
    input  logic [5:0]   mem_address,
    output logic         mem_busywait,
    output logic [127:0] mem_readdata,
    input  logic         prog_we,
    input  logic [9:0]   prog_addr,
    input  logic [7:0]   prog_wdata
);

    // state  | meaning
    // S_IDLE | waiting for mem_read; block address latched on the request edge
    // S_BUSY | latency countdown in r_cnt; block captured when it reaches zero
    // S_DONE | one cycle with busywait low so the cache sees completion
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAT_LOAD = 8'(READ_LATENCY - 1);

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic [5:0]     r_blk;
    logic [127:0]   r_readdata;
    logic [7:0]     r_mem [0:1023];
    logic [127:0]   w_block;

    // Storage is never reset so a loaded program survives a controller reset.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_comb begin
        w_block = '0;
        for (int k = 0; k < 16; k++) begin
            w_block[8*k +: 8] = r_mem[{r_blk, 4'(k)}];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_blk      <= 6'd0;
            r_readdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_read) begin
                        r_blk   <= mem_address;
                        r_cnt   <= LAT_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!mem_read) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_readdata <= w_block;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational so the cache stalls in the very cycle it raises mem_read.
    assign mem_busywait = ((r_state == S_IDLE) && mem_read) || (r_state == S_BUSY);
    assign mem_readdata = r_readdata;

endmodule

// File: tb/tb_imem_block_reader.sv
// Randomised plus directed bench for imem_block_reader; two instances (latency 5 and 1)
// share the programming port and are checked every cycle against a transaction-level model.
module tb_imem_block_reader;

    localparam logic [127:0] P1 = 128'h0F0E0D0C0B0A09080706050403020100;

    logic         clock;
    logic         reset;
    logic         prog_we;
    logic [9:0]   prog_addr;
    logic [7:0]   prog_wdata;
    logic         rd [2];
    logic [5:0]   ad [2];
    logic         bw [2];
    logic [127:0] dq [2];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    imem_block_reader #(.READ_LATENCY(5)) dut (
        .clock(clock), .reset(reset),
        .mem_read(rd[0]), .mem_address(ad[0]),
        .mem_busywait(bw[0]), .mem_readdata(dq[0]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    imem_block_reader #(.READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .mem_read(rd[1]), .mem_address(ad[1]),
        .mem_busywait(bw[1]), .mem_readdata(dq[1]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else n_pass++;
    endtask

    // Transaction-level model: a request is in flight for LAT cycles after acceptance,
    // then a one-cycle completion during which the block read from the model memory shows up.
    logic [7:0]   m_mem [1024];
    bit           m_act  [2];
    bit           m_done [2];
    int           m_el   [2];
    int           m_blk  [2];
    logic [127:0] m_data [2];
    int           lat    [2] = '{5, 1};

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_act[d] = 0; m_done[d] = 0; m_data[d] = '0;
            end else if (m_done[d]) begin
                m_done[d] = 0;
            end else if (!m_act[d]) begin
                if (rd[d]) begin
                    m_act[d] = 1; m_el[d] = 1; m_blk[d] = int'(ad[d]);
                end
            end else if (!rd[d]) begin
                m_act[d] = 0;
            end else if (m_el[d] == lat[d]) begin
                for (int k = 0; k < 16; k++) m_data[d][8*k +: 8] = m_mem[m_blk[d]*16 + k];
                m_act[d] = 0; m_done[d] = 1;
            end else begin
                m_el[d]++;
            end
        end
        if (prog_we) m_mem[prog_addr] = prog_wdata;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busywait[%0d]", d), 128'(bw[d]),
                    128'(m_act[d] || (!m_done[d] && rd[d])));
                chk($sformatf("readdata[%0d]", d), dq[d], m_data[d]);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Raise mem_read and count busy cycles; returns at the negedge of the first non-busy cycle.
    task automatic req_count(input int d, input logic [5:0] a, output int n);
        rd[d] = 1'b1;
        ad[d] = a;
        n = 0;
        repeat (50) begin
            @(negedge clock);
            if (bw[d]) n++;
            else break;
        end
    endtask

    task automatic wait_not_busy(input int d);
        int i;
        i = 0;
        while (bw[d] && i < 50) begin
            @(negedge clock);
            i++;
        end
        if (i >= 50) chk("wait_timeout", 128'(bw[d]), 128'(0));
    endtask

    int n;

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        rd[0] = 1'b0; rd[1] = 1'b0; ad[0] = '0; ad[1] = '0;
        step();
        chk_en = 1;
        step();
        reset = 1'b0;
        step();
        @(negedge clock);
        chk("rst_busy", 128'(bw[0]), 128'(0));
        chk("rst_data", dq[0], 128'(0));
        step();

        for (int i = 0; i < 1024; i++) begin
            prog_we = 1'b1;
            prog_addr = 10'(i);
            if (i >= 16 && i < 32) prog_wdata = 8'(i - 16);
            else if (i == 'h70)    prog_wdata = 8'hFF;
            else                   prog_wdata = 8'($urandom);
            step();
        end
        prog_we = 1'b0;

        req_count(0, 6'd1, n);
        chk("lat5_busy_cycles", 128'(n), 128'(6));
        chk("lat5_block1", dq[0], P1);
        step(); rd[0] = 1'b0;

        req_count(1, 6'd1, n);
        chk("lat1_busy_cycles", 128'(n), 128'(2));
        chk("lat1_block1", dq[1], P1);
        step(); rd[1] = 1'b0;

        req_count(0, 6'd7, n);
        chk("block7_byte0", 128'(dq[0][7:0]), 128'(8'hFF));
        step(); rd[0] = 1'b0;

        rd[0] = 1'b1; ad[0] = 6'd1;
        step(); step();
        ad[0] = 6'd7;
        wait_not_busy(0);
        chk("addr_change_ignored", dq[0], P1);
        step(); rd[0] = 1'b0;

        rd[0] = 1'b1; ad[0] = 6'd7;
        step(); step(); step();
        rd[0] = 1'b0;
        @(negedge clock);
        chk("abort_busy_in_busy", 128'(bw[0]), 128'(1));
        step();
        @(negedge clock);
        chk("abort_busy_low", 128'(bw[0]), 128'(0));
        chk("abort_data_kept", dq[0], P1);
        step();

        rd[0] = 1'b1; ad[0] = 6'd2;
        step(); step();
        reset = 1'b1; rd[0] = 1'b0;
        step();
        @(negedge clock);
        chk("rst_mid_busy", 128'(bw[0]), 128'(0));
        chk("rst_mid_data", dq[0], 128'(0));
        step();
        reset = 1'b0;
        req_count(0, 6'd2, n);
        chk("after_rst_busy_cycles", 128'(n), 128'(6));
        step(); rd[0] = 1'b0;

        rd[0] = 1'b1; ad[0] = 6'd1;
        step(); step(); step();
        prog_we = 1'b1; prog_addr = 10'h15; prog_wdata = 8'hAA;
        step();
        prog_we = 1'b0;
        wait_not_busy(0);
        chk("write_before_capture", 128'(dq[0][47:40]), 128'(8'hAA));
        step(); rd[0] = 1'b0;

        prog_we = 1'b1; prog_addr = 10'h15; prog_wdata = 8'h05;
        step();
        prog_we = 1'b0;
        rd[0] = 1'b1; ad[0] = 6'd1;
        step(); step(); step(); step(); step();
        prog_we = 1'b1; prog_addr = 10'h15; prog_wdata = 8'hAA;
        step();
        prog_we = 1'b0;
        @(negedge clock);
        chk("write_at_capture_busy", 128'(bw[0]), 128'(0));
        chk("write_at_capture_old", 128'(dq[0][47:40]), 128'(8'h05));
        step(); rd[0] = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int d = 0; d < 2; d++) begin
                rd[d] = rd[d] ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) == 0) ad[d] = 6'($urandom_range(0, 3));
            end
            prog_we    = ($urandom_range(0, 5) == 0);
            prog_addr  = 10'($urandom_range(0, 63));
            prog_wdata = 8'($urandom);
            step();
        end
        reset = 1'b0; prog_we = 1'b0; rd[0] = 1'b0; rd[1] = 1'b0;
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
